stream_demux1to4: RTL and testbench
===================================

Name: stream_demux1to4

Overview:
- Inverse of the codebase's 4:1 selector: routes one input beat stream to one of four output channels.
- Valid/ready handshakes on both sides.
- Routing is packet-locked: the destination is sampled on the first beat of a packet and held until the beat carrying `in_last`.
- One registered output stage, so latency is 1 cycle and throughput is 1 beat/cycle.

Parameters:
- DATA_W, 8, width of the data beat.
- NUM_OUT, 4, number of output channels; fixed at 4, not overridable.
- SEL_W, 2, destination select width; fixed at 2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  DATA_W  input beat payload.
- in_last  in  1  final beat of the packet.
- in_sel  in  2  destination channel; sampled only on the first beat of a packet.
- out_valid  out  4  one-hot; bit k means a beat is offered to channel k.
- out_ready  in  4  per-channel sink ready.
- out_data  out  DATA_W  shared payload bus for all channels.
- out_last  out  1  last flag of the offered beat.
- pkt_cnt  out  64  only present with DEMUX_PKT_CNT_EN; four 16-bit counters, channel k in bits [16k+15:16k].

Behaviour:
- Registers:
  - full: output stage occupied.
  - dst[1:0]: destination of the held beat.
  - out_data, out_last.
  - lock[1:0]: locked destination for the current packet.
  - state: IDLE or BUSY.
- Reset (rst=1 at edge):
  - full=0, out_valid=0000, out_data=0, out_last=0, lock=0, state=IDLE, counters=0.
  - in_ready=0 while rst is high (combinational gate).
- Ready and accept:
  - in_ready = !rst & (!full | out_ready[dst]). This is a combinational path from out_ready.
  - Accept = in_valid & in_ready.
  - Drain = full & out_ready[dst].
  - out_ready bits of non-selected channels are ignored.
- Routing:
  - Accept in IDLE: beat goes to in_sel, and lock<=in_sel. If in_last=0, state<=BUSY; otherwise stay IDLE (single-beat packet).
  - Accept in BUSY: beat goes to lock, and in_sel is ignored. On in_last=1, state<=IDLE.
- Output stage:
  - On accept: out_data<=in_data, out_last<=in_last, dst<=routed destination, full<=1.
  - On drain without accept: full<=0; out_data and out_last retain their values.
  - Drain and accept in the same cycle: the register is reloaded and full stays 1 (no bubble).
- out_valid = full ? onehot(dst) : 4'b0000. Never more than one bit is set.
- Latency: a beat accepted at edge N is offered from cycle N+1.
- Reset mid-packet: the held beat is discarded and the FSM returns to IDLE. The next accepted beat is treated as a packet start.
- in_valid deasserting mid-packet is legal; the lock is held indefinitely.

Optional Feature:
- Macro: DEMUX_PKT_CNT_EN.
- Defined:
  - pkt_cnt port exists.
  - Counter k increments by 1 on each drain with dst=k and out_last=1.
  - 16-bit wrap-around from 0xFFFF to 0x0000.
  - Cleared by rst.
- Undefined: no pkt_cnt port, no counter logic; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - NUM_OUT=4, SEL_W=2, CNT_W=16.
  - state enum {IDLE=1'b0, BUSY=1'b1}.
- Sub-module dec2to4: combinational 2-bit to 4-bit one-hot decoder with an enable input. Used for out_valid and counter strobes.
- Everything else stays in stream_demux1to4.

Test Plan:
- Reset check: rst high for 3 cycles with in_valid=1 -> in_ready=0, out_valid=0000, out_data=0x00 throughout. After release, in_ready=1.
- Single-beat packet: in_sel=2, data 0xA5, last=1, out_ready=1111 -> next cycle out_valid=0100, out_data=0xA5, out_last=1. State remains IDLE.
- Locked packet: 3 beats 0x11, 0x22, 0x33 with in_sel toggling 1,3,0 and last on 0x33 -> all three appear on out_valid=0010. Next packet with in_sel=3 routes to 1000.
- Backpressure: out_ready[0]=0 while streaming to ch0 -> after one beat is held, in_ready=0 and out_data is stable. With out_ready=1110 (other channels ready), still stalled. Raising out_ready[0] gives back-to-back drain, 1 beat/cycle with no bubble.
- Reset mid-packet: rst after 2 of 4 beats to ch1 -> out_valid=0000. A following beat with in_sel=3, last=1 appears on ch3.
- Counter wrap (DEMUX_PKT_CNT_EN): 65537 single-beat packets to ch2 -> pkt_cnt[47:32]=0x0001, other fields 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
// Channel count and select width are fixed; only the payload width is a parameter.
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/stream_demux1to4_dec2to4.sv
// 2-bit to 4-bit one-hot decoder with enable; all-zero output when disabled.
module dec2to4
  import demux_pkg::*;
(
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot
);

  // NOTE: assign a default before any conditional write in always_comb, otherwise a latch is inferred.
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/stream_demux1to4.sv
// Packet-locked 1:4 valid/ready stream demux with a single registered output stage.
// Optional per-channel packet counters on pkt_cnt when DEMUX_PKT_CNT_EN is defined.
module stream_demux1to4
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last
`ifdef DEMUX_PKT_CNT_EN
  ,
  output logic [NUM_OUT*CNT_W-1:0] pkt_cnt
`endif
);

  state_t           state, state_nxt;
  logic             full;
  logic [SEL_W-1:0] dst;
  logic [SEL_W-1:0] lock;
  logic [SEL_W-1:0] route;
  logic             sel_ready;
  logic             accept;
  logic             drain;

  // Only the ready of the channel holding the current beat matters.
  assign sel_ready = out_ready[dst];
  assign in_ready  = !rst && (!full || sel_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = full && sel_ready;
  assign route     = (state == IDLE) ? in_sel : lock;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (state == IDLE) begin
        if (!in_last) state_nxt = BUSY;
      end else if (in_last) begin
        state_nxt = IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock     <= '0;
      full     <= 1'b0;
      dst      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && state == IDLE) lock <= in_sel;
      // A same-cycle drain and accept reloads the stage without a bubble.
      if (accept) begin
        full     <= 1'b1;
        dst      <= route;
        out_data <= in_data;
        out_last <= in_last;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

  dec2to4 u_valid_dec (
    .en     (full),
    .sel    (dst),
    .onehot (out_valid)
  );

`ifdef DEMUX_PKT_CNT_EN
  logic [NUM_OUT-1:0] cnt_strobe;
  logic [CNT_W-1:0]   cnt [NUM_OUT];

  dec2to4 u_cnt_dec (
    .en     (drain && out_last),
    .sel    (dst),
    .onehot (cnt_strobe)
  );

  // NOTE: this small register array is reset explicitly; it is flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++)
        if (cnt_strobe[k]) cnt[k] <= cnt[k] + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_pack
    assign pkt_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end
`endif

endmodule

// File: tb/tb_stream_demux1to4.sv
// Self-checking bench for stream_demux1to4: vector table, hand sequences, random vs queue model.
module tb_stream_demux1to4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [1:0] in_sel;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_data;
  logic       out_last;
`ifdef DEMUX_PKT_CNT_EN
  logic [63:0] pkt_cnt;
  int unsigned exp_cnt [4];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_demux1to4 #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef DEMUX_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [1:0] s;
    logic [3:0] o;
    logic       e_ir;
    logic [3:0] e_ov;
    logic [7:0] e_od;
    logic       e_ol;
  } vec_t;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  vec_t  vecs [12];
  beat_t beat_q [$];
  logic  pkt_open;
  logic [1:0] pkt_ch;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic l,
                       input logic [1:0] s, input logic [3:0] o);
    rst = r; in_valid = v; in_data = d; in_last = l; in_sel = s; out_ready = o;
  endtask

  // Drive one cycle, compare at the falling edge, then advance past the rising edge.
  task automatic step(input string tag, input vec_t t);
    drive(t.r, t.v, t.d, t.l, t.s, t.o);
    @(negedge clk);
    check({tag, "_in_ready"},  64'(in_ready),  64'(t.e_ir));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(t.e_ov));
    check({tag, "_out_data"},  64'(out_data),  64'(t.e_od));
    check({tag, "_out_last"},  64'(out_last),  64'(t.e_ol));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, single-beat packet, locked 3-beat packet, following packet to ch3.
    vecs[0]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 2'd2, 4'hF, 1'b1, 4'b0000, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0100, 8'hA5, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b0, 2'd1, 4'hF, 1'b1, 4'b0000, 8'hA5, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2'd3, 4'hF, 1'b1, 4'b0010, 8'h11, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h33, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 8'h22, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h44, 1'b1, 2'd3, 4'hF, 1'b1, 4'b0010, 8'h33, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b1000, 8'h44, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 8'h44, 1'b1};

    drive(1'b1, 1'b1, 8'hFF, 1'b1, 2'd0, 4'hF);
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) step($sformatf("vec%0d", i), vecs[i]);

    // Backpressure on ch0 with other channels ready, then back-to-back release.
    step("bp0", '{1'b0, 1'b1, 8'h50, 1'b0, 2'd0, 4'b1110, 1'b1, 4'b0000, 8'h44, 1'b1});
    for (int i = 0; i < 3; i++)
      step($sformatf("bp_stall%0d", i),
           '{1'b0, 1'b1, 8'h51, 1'b0, 2'd2, 4'b1110, 1'b0, 4'b0001, 8'h50, 1'b0});
    step("bp_go1", '{1'b0, 1'b1, 8'h51, 1'b0, 2'd2, 4'hF, 1'b1, 4'b0001, 8'h50, 1'b0});
    step("bp_go2", '{1'b0, 1'b1, 8'h52, 1'b0, 2'd2, 4'hF, 1'b1, 4'b0001, 8'h51, 1'b0});
    step("bp_go3", '{1'b0, 1'b1, 8'h53, 1'b1, 2'd2, 4'hF, 1'b1, 4'b0001, 8'h52, 1'b0});
    step("bp_tail", '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0001, 8'h53, 1'b1});
    step("bp_empty", '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 8'h53, 1'b1});

    // Reset in the middle of a ch1 packet; next beat must start a fresh packet.
    step("mr1", '{1'b0, 1'b1, 8'h61, 1'b0, 2'd1, 4'hF, 1'b1, 4'b0000, 8'h53, 1'b1});
    step("mr2", '{1'b0, 1'b1, 8'h62, 1'b0, 2'd2, 4'hF, 1'b1, 4'b0010, 8'h61, 1'b0});
    step("mr_rst", '{1'b1, 1'b1, 8'h63, 1'b0, 2'd2, 4'hF, 1'b0, 4'b0010, 8'h62, 1'b0});
    step("mr_new", '{1'b0, 1'b1, 8'h70, 1'b1, 2'd3, 4'hF, 1'b1, 4'b0000, 8'h00, 1'b0});
    step("mr_out", '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b1000, 8'h70, 1'b1});

    // Random traffic against a queue-based packet model.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
    @(posedge clk);
    #1;
    beat_q.delete();
    pkt_open = 1'b0;
    pkt_ch   = 2'd0;
`ifdef DEMUX_PKT_CNT_EN
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
`endif
    for (int n = 0; n < 3000; n++) begin
      logic       r, v, l, e_ir, drn, acc;
      logic [7:0] d;
      logic [1:0] s, ch;
      logic [3:0] o;
      r = ($urandom_range(63) == 0);
      v = ($urandom_range(3) != 0);
      l = ($urandom_range(2) == 0);
      d = 8'($urandom);
      s = 2'($urandom);
      for (int k = 0; k < 4; k++) o[k] = ($urandom_range(3) != 0);
      drive(r, v, d, l, s, o);
      @(negedge clk);
      e_ir = !r && (beat_q.size() == 0 || o[beat_q[0].ch]);
      check("rnd_in_ready", 64'(in_ready), 64'(e_ir));
      if (beat_q.size() == 0) begin
        check("rnd_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("rnd_out_valid", 64'(out_valid), 64'(1) << beat_q[0].ch);
        check("rnd_out_data", 64'(out_data), 64'(beat_q[0].data));
        check("rnd_out_last", 64'(out_last), 64'(beat_q[0].last));
      end
      if (r) begin
        beat_q.delete();
        pkt_open = 1'b0;
`ifdef DEMUX_PKT_CNT_EN
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
`endif
      end else begin
        drn = (beat_q.size() != 0) && o[beat_q[0].ch];
        acc = v && e_ir;
        if (drn) begin
`ifdef DEMUX_PKT_CNT_EN
          if (beat_q[0].last) exp_cnt[beat_q[0].ch] = (exp_cnt[beat_q[0].ch] + 1) % 65536;
`endif
          void'(beat_q.pop_front());
        end
        if (acc) begin
          ch = pkt_open ? pkt_ch : s;
          beat_q.push_back('{ch, d, l});
          pkt_open = !l;
          pkt_ch   = ch;
        end
      end
      @(posedge clk);
      #1;
    end
`ifdef DEMUX_PKT_CNT_EN
    drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
    @(negedge clk);
    check("rnd_pkt_cnt", pkt_cnt,
          {16'(exp_cnt[3]), 16'(exp_cnt[2]), 16'(exp_cnt[1]), 16'(exp_cnt[0])});

    // 65537 single-beat packets to ch2 wrap that counter to 1.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 8'h5A, 1'b1, 2'd2, 4'hF);
    for (int n = 0; n < 65537; n++) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("wrap_pkt_cnt", pkt_cnt, 64'h0000_0001_0000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
